// File: rtl/cic_cfg_ctrl.sv
// Configuration sequencer for the DDC decimating CIC: accepts, range-checks, loads and
// sample-aligned commits a CIC parameter word. Optional ALIGN timeout via CIC_CFG_TIMEOUT_EN.
module cic_cfg_ctrl #(
   parameter int unsigned MAX_SHIFT     = 25,
   parameter int unsigned ALIGN_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        param_rst_req,
   input  logic        cfg_req,
   input  logic [15:0] cfg_data,
   output logic        cfg_ack,
   output logic        cfg_err,
   output logic        cfg_done,
   output logic        cfg_busy,
   output logic [15:0] cur_param,
   input  logic        cic_flag,
   output logic        cic_indicator,
   output logic [15:0] cic_param,
   output logic        config_sync,
   output logic        rst_param,
   output logic        data_valid
);

   localparam int unsigned WORD_W = 16;
   localparam int unsigned FLD_W  = 5;
   localparam logic [WORD_W-1:0] DEFAULT_PARAM = 16'h03E3;
   localparam logic [WORD_W-1:0] RSVD_MASK     = 16'h7FFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      LOAD  = 3'd2,
      ALIGN = 3'd3,
      SYNC  = 3'd4,
      FLUSH = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] staged;
   logic [FLD_W-1:0]  flush_cnt;
   logic              prst_hold;

   logic [FLD_W-1:0]  st_order;
   logic [FLD_W-1:0]  st_decim;
   logic [FLD_W-1:0]  st_shift;
   logic              legal;

   logic              accept;
   logic              err_set;
   logic              err_clr;
   logic              load_go;
   logic              sync_go;
   logic              done_go;
   logic              tmo_hit;

   // Field decode of the staged word
   assign st_order = staged[4:0];
   assign st_decim = staged[9:5];
   assign st_shift = staged[14:10];

   assign legal = (st_order >= FLD_W'(3)) && (st_order <= FLD_W'(5)) &&
                  (st_decim != '0) && (32'(st_shift) <= MAX_SHIFT);

`ifdef CIC_CFG_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(ALIGN_TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Counts cycles spent in ALIGN; cleared whenever ALIGN is left
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (state == ALIGN) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end

   assign tmo_hit = (state == ALIGN) && (tmo_cnt == TMO_W'(ALIGN_TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and strobe decode; a parameter reset overrides everything
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
      load_go   = 1'b0;
      sync_go   = 1'b0;
      done_go   = 1'b0;

      case (state)
         IDLE: begin
            if (cfg_req) begin
               accept    = 1'b1;
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (legal) begin
               err_clr   = 1'b1;
               load_go   = 1'b1;
               state_nxt = LOAD;
            end else begin
               err_set   = 1'b1;
               state_nxt = IDLE;
            end
         end
         LOAD: begin
            state_nxt = ALIGN;
         end
         ALIGN: begin
            if (cic_flag || tmo_hit) begin
               sync_go   = 1'b1;
               state_nxt = SYNC;
            end
         end
         SYNC: begin
            state_nxt = FLUSH;
         end
         FLUSH: begin
            if (cic_flag && (flush_cnt <= FLD_W'(1))) begin
               done_go   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (param_rst_req) begin
         state_nxt = IDLE;
         accept    = 1'b0;
         err_set   = 1'b0;
         err_clr   = 1'b0;
         load_go   = 1'b0;
         sync_go   = 1'b0;
         done_go   = 1'b0;
      end
   end

   // Host handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_ack  <= 1'b0;
         cfg_err  <= 1'b0;
         cfg_done <= 1'b0;
         cfg_busy <= 1'b0;
         staged   <= DEFAULT_PARAM;
      end else begin
         cfg_ack  <= accept;
         cfg_done <= done_go;
         cfg_busy <= (state_nxt != IDLE);
         if (accept) begin
            staged <= cfg_data & RSVD_MASK;
         end
         if (err_set) begin
            cfg_err <= 1'b1;
         end else if (err_clr) begin
            cfg_err <= 1'b0;
         end
      end
   end

   // Filter-side strobes and parameter word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cic_indicator <= 1'b0;
         config_sync   <= 1'b0;
         cic_param     <= DEFAULT_PARAM;
         data_valid    <= 1'b0;
      end else begin
         cic_indicator <= load_go;
         config_sync   <= sync_go;
         data_valid    <= cic_flag && (state != FLUSH);
         if (load_go) begin
            cic_param <= staged;
         end
      end
   end

   // Commit bookkeeping; the flag that ended ALIGN is never counted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_param <= DEFAULT_PARAM;
         flush_cnt <= '0;
      end else begin
         if (param_rst_req) begin
            cur_param <= DEFAULT_PARAM;
         end else if (state == SYNC) begin
            cur_param <= staged;
         end
         if (state == SYNC) begin
            flush_cnt <= st_order + FLD_W'(1);
         end else if ((state == FLUSH) && cic_flag && (flush_cnt != '0)) begin
            flush_cnt <= flush_cnt - FLD_W'(1);
         end
      end
   end

   // Two-cycle active-low filter parameter reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prst_hold <= 1'b0;
         rst_param <= 1'b0;
      end else begin
         prst_hold <= param_rst_req;
         rst_param <= !(param_rst_req || prst_hold);
      end
   end

endmodule

// File: tb/tb_cic_cfg_ctrl.sv
// Directed bench for cic_cfg_ctrl: expected filter words queued at request time and
// checked when the DUT strobes cic_indicator / cfg_done.
module tb_cic_cfg_ctrl;

   logic        clk;
   logic        rst;
   logic        param_rst_req;
   logic        cfg_req;
   logic [15:0] cfg_data;
   logic        cfg_ack;
   logic        cfg_err;
   logic        cfg_done;
   logic        cfg_busy;
   logic [15:0] cur_param;
   logic        cic_flag;
   logic        cic_indicator;
   logic [15:0] cic_param;
   logic        config_sync;
   logic        rst_param;
   logic        data_valid;

   int          errors = 0;
   int          checks = 0;
   int          ph = 0;
   bit          flag_en = 0;
   logic        pflag = 0;
   logic [15:0] exp_cur = 16'h03E3;
   logic [15:0] exp_q[$];

   cic_cfg_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .param_rst_req (param_rst_req),
      .cfg_req       (cfg_req),
      .cfg_data      (cfg_data),
      .cfg_ack       (cfg_ack),
      .cfg_err       (cfg_err),
      .cfg_done      (cfg_done),
      .cfg_busy      (cfg_busy),
      .cur_param     (cur_param),
      .cic_flag      (cic_flag),
      .cic_indicator (cic_indicator),
      .cic_param     (cic_param),
      .config_sync   (config_sync),
      .rst_param     (rst_param),
      .data_valid    (data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, want);
      end
   endtask

   // Advance to the next falling edge; cic_flag pulses every 4th cycle when enabled
   task automatic tick();
      @(negedge clk);
      pflag = cic_flag;
      if (flag_en) begin
         ph       = (ph + 1) % 4;
         cic_flag = (ph == 0);
      end else begin
         cic_flag = 1'b0;
      end
   endtask

   task automatic wait_sync(output bit got);
      got = 0;
      for (int n = 0; n < 100 && !got; n++) begin
         tick();
         if (config_sync) got = 1;
      end
   endtask

   task automatic run_cfg(input logic [15:0] word, input bit legal);
      logic [15:0] w;
      bit          got;
      bit          saw;
      int          flags;
      w = word & 16'h7FFF;
      cfg_req  = 1'b1;
      cfg_data = word;
      if (legal) exp_q.push_back(w);
      tick();
      chk("ack", 16'(cfg_ack), 16'd1);
      chk("busy_check", 16'(cfg_busy), 16'd1);
      cfg_req = 1'b0;
      tick();
      chk("ack_pulse", 16'(cfg_ack), 16'd0);
      chk("err", 16'(cfg_err), 16'(!legal));
      chk("indicator", 16'(cic_indicator), 16'(legal));
      if (!legal) begin
         chk("busy_after_err", 16'(cfg_busy), 16'd0);
         saw = 0;
         for (int n = 0; n < 8; n++) begin
            tick();
            saw = saw | cic_indicator | config_sync;
         end
         chk("no_strobes", 16'(saw), 16'd0);
         chk("cur_keep", cur_param, exp_cur);
         return;
      end
      if (exp_q.size() > 0) w = exp_q.pop_front();
      else w = 16'hxxxx;
      chk("cic_param", cic_param, w);
      wait_sync(got);
      chk("sync_seen", 16'(got), 16'd1);
      chk("sync_after_flag", 16'(pflag), 16'd1);
      chk("dv_align", 16'(data_valid), 16'd1);
      flags = 0;
      got   = 0;
      for (int n = 0; n < 60 && !got; n++) begin
         tick();
         if (pflag) begin
            flags++;
            chk("dv_mask", 16'(data_valid), 16'd0);
         end
         if (cfg_done) got = 1;
      end
      chk("done_seen", 16'(got), 16'd1);
      chk("flush_flags", 16'(flags), 16'(word[4:0]) + 16'd1);
      chk("busy_done", 16'(cfg_busy), 16'd0);
      exp_cur = w;
      chk("cur_param", cur_param, exp_cur);
      tick();
      chk("done_pulse", 16'(cfg_done), 16'd0);
   endtask

   initial begin
      bit got;
      int sync_at;
      rst           = 1'b0;
      param_rst_req = 1'b0;
      cfg_req       = 1'b0;
      cfg_data      = 16'h0000;
      cic_flag      = 1'b0;

      repeat (3) tick();
      chk("rst_ack", 16'(cfg_ack), 16'd0);
      chk("rst_err", 16'(cfg_err), 16'd0);
      chk("rst_done", 16'(cfg_done), 16'd0);
      chk("rst_busy", 16'(cfg_busy), 16'd0);
      chk("rst_ind", 16'(cic_indicator), 16'd0);
      chk("rst_sync", 16'(config_sync), 16'd0);
      chk("rst_rst_param", 16'(rst_param), 16'd0);
      chk("rst_dv", 16'(data_valid), 16'd0);
      chk("rst_cur", cur_param, 16'h03E3);
      chk("rst_cic_param", cic_param, 16'h03E3);
      rst = 1'b1;
      tick();
      chk("rst_param_rise", 16'(rst_param), 16'd1);

      flag_en = 1;
      repeat (3) tick();
      run_cfg(16'h1484, 1);
      run_cfg(16'h0086, 0);
      run_cfg(16'h1484, 1);
      run_cfg(16'h6883, 0);
      run_cfg(16'h0003, 0);
      run_cfg(16'hE485, 1);

      // Parameter reset in the middle of a flush
      cfg_req  = 1'b1;
      cfg_data = 16'h1484;
      exp_q.push_back(16'h1484);
      tick();
      cfg_req = 1'b0;
      tick();
      chk("prst_ind", 16'(cic_indicator), 16'd1);
      if (exp_q.size() > 0) chk("prst_cic_param", cic_param, exp_q.pop_front());
      wait_sync(got);
      chk("prst_sync_seen", 16'(got), 16'd1);
      repeat (2) tick();
      param_rst_req = 1'b1;
      tick();
      param_rst_req = 1'b0;
      exp_cur = 16'h03E3;
      chk("prst_low1", 16'(rst_param), 16'd0);
      chk("prst_busy", 16'(cfg_busy), 16'd0);
      chk("prst_cur", cur_param, exp_cur);
      chk("prst_err_keep", 16'(cfg_err), 16'd0);
      tick();
      chk("prst_low2", 16'(rst_param), 16'd0);
      tick();
      chk("prst_high", 16'(rst_param), 16'd1);
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         tick();
         if (pflag) got = 1;
      end
      chk("prst_flag_seen", 16'(got), 16'd1);
      chk("prst_dv_follow", 16'(data_valid), 16'd1);
      chk("prst_no_done", 16'(cfg_done), 16'd0);

      // ALIGN with no filter strobes
      flag_en = 0;
      tick();
      cfg_req  = 1'b1;
      cfg_data = 16'h1484;
      exp_q.push_back(16'h1484);
      tick();
      cfg_req = 1'b0;
      chk("tmo_ack", 16'(cfg_ack), 16'd1);
      tick();
      chk("tmo_ind", 16'(cic_indicator), 16'd1);
      if (exp_q.size() > 0) chk("tmo_cic_param", cic_param, exp_q.pop_front());
      sync_at = 0;
      for (int i = 1; i <= 100 && sync_at == 0; i++) begin
         tick();
         if (config_sync) sync_at = i;
      end
`ifdef CIC_CFG_TIMEOUT_EN
      chk("tmo_sync_at", 16'(sync_at), 16'd65);
`else
      chk("tmo_never", 16'(sync_at), 16'd0);
`endif
      chk("tmo_busy", 16'(cfg_busy), 16'd1);
      param_rst_req = 1'b1;
      tick();
      param_rst_req = 1'b0;
      chk("tmo_prst_busy", 16'(cfg_busy), 16'd0);
      chk("tmo_prst_cur", cur_param, exp_cur);
      repeat (3) tick();
      chk("tmo_idle_busy", 16'(cfg_busy), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
